// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-chain loader.
//   cfg_state_t : loader FSM states.
//   cnt_width() : width of a counter that has to hold 0..max_value inclusive.
package cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FETCH  = 3'd2,
    SHIFT  = 3'd3,
    DRAIN  = 3'd4,
    FINISH = 3'd5
  } cfg_state_t;

  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/cfg_word_serdes.sv
// One-word shift register with a bit counter. Bits leave at bit 0 and enter
// at the MSB, so the same block serves as a parallel-to-serial converter
// (load a word, shift it out) and a serial-to-parallel converter (shift bits
// in, take 'assembled').
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   clear         : empty the register and zero the counter (highest priority)
//   load          : capture load_data and zero the counter
//   load_data     : parallel word to serialise
//   shift         : move one bit: word <= {serial_in, word[W-1:1]}, count++
//   serial_in     : bit entering at the MSB on a shift
//   serial_out    : bit 0 of the stored word (the next bit to leave)
//   assembled     : stored bits plus serial_in, right-aligned so the first bit
//                   received sits in bit 0 and unused upper bits are zero
//   count         : bits shifted since the last clear/load
//   count_next    : value count takes at the next edge
// WORD_WIDTH must be at least 2.
module cfg_word_serdes
  import cfg_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  load,
  input  logic [WORD_WIDTH-1:0]                 load_data,
  input  logic                                  shift,
  input  logic                                  serial_in,
  output logic                                  serial_out,
  output logic [WORD_WIDTH-1:0]                 assembled,
  output logic [cnt_width(WORD_WIDTH)-1:0]      count,
  output logic [cnt_width(WORD_WIDTH)-1:0]      count_next
);

  localparam int CW = cnt_width(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] word;
  logic [WORD_WIDTH-1:0] shifted;
  logic [CW-1:0]         shamt;

  assign shifted    = {serial_in, word[WORD_WIDTH-1:1]};
  assign serial_out = word[0];

  // After count+1 bits have entered at the MSB they occupy the top count+1
  // positions; shifting down by W-1-count puts the first one in bit 0.
  assign shamt     = CW'(WORD_WIDTH - 1) - count;
  assign assembled = shifted >> shamt;

  always_comb begin
    count_next = count;
    if (clear || load) begin
      count_next = '0;
    end else if (shift) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (clear) begin
        word <= '0;
      end else if (load) begin
        word <= load_data;
      end else if (shift) begin
        word <= shifted;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Initiator end of the fabric configuration chain.
// Write load: clear the chain for CLEAR_CYCLES cycles, then fetch words over
// wr_* and serialise exactly CHAIN_BITS bits (bit 0 of each word first).
// Readback: recirculate the chain tail into the head for CHAIN_BITS shifts,
// returning the tail bits as rd_* words (first bit in bit 0, last word
// zero-padded). The chain contents are unchanged afterwards.
// Handshakes: a word transfers on a rising clock edge where valid and ready
// are both 1; valid, once raised, holds with stable data until that edge.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   start, readback         : operation request (sampled in IDLE) and mode
//   wr_data/valid/ready     : bitstream word stream in
//   rd_data/valid/ready     : readback word stream out
//   busy, done              : activity flag, completion pulse
//   cfg_data_out/cfg_data_in: chain head / chain tail
//   cfg_enable, cfg_nreset  : chain shift enable, active-low chain clear
//   state_dbg               : current FSM state encoding (cfg_state_t)
module config_loader
  import cfg_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_BITS   = 4096,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  readback,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_data_out,
  input  logic                  cfg_data_in,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  output logic [2:0]            state_dbg
);

  localparam int BW  = cnt_width(CHAIN_BITS);
  localparam int WCW = cnt_width(WORD_WIDTH);
  localparam int CCW = cnt_width(CLEAR_CYCLES);

  cfg_state_t state, state_n;
  logic          mode_rb, mode_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [CCW-1:0] clr_cnt, clr_cnt_n;
  logic [WORD_WIDTH-1:0] rd_data_n;
  logic          rd_valid_n;
  logic          wr_ready_n, busy_n, done_n, cfg_enable_n, cfg_nreset_n;

  logic          tx_clear, tx_load, tx_shift, tx_serial;
  logic [WCW-1:0] tx_count;
  logic [WORD_WIDTH-1:0] tx_assembled_unused;
  logic [WCW-1:0] tx_count_next_unused;

  logic          rx_clear, rx_shift, rx_serial_unused;
  logic [WORD_WIDTH-1:0] rx_assembled;
  logic [WCW-1:0] rx_count, rx_count_next;

  logic          shifting, last_bit, rd_word_due_n;

  cfg_word_serdes #(.WORD_WIDTH(WORD_WIDTH)) u_tx (
    .clock      (clock),
    .reset      (reset),
    .clear      (tx_clear),
    .load       (tx_load),
    .load_data  (wr_data),
    .shift      (tx_shift),
    .serial_in  (1'b0),
    .serial_out (tx_serial),
    .assembled  (tx_assembled_unused),
    .count      (tx_count),
    .count_next (tx_count_next_unused)
  );

  cfg_word_serdes #(.WORD_WIDTH(WORD_WIDTH)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .clear      (rx_clear),
    .load       (1'b0),
    .load_data  ('0),
    .shift      (rx_shift),
    .serial_in  (cfg_data_in),
    .serial_out (rx_serial_unused),
    .assembled  (rx_assembled),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

  // In readback the tail is fed straight back to the head so the bit that
  // leaves the chain on an edge re-enters it on that same edge; a register in
  // this path would lengthen the ring by one and rotate the contents.
  assign cfg_data_out = mode_rb ? cfg_data_in : tx_serial;
  assign state_dbg    = state;

  // cfg_enable is registered, so a 1 here means a bit moves at the coming edge.
  assign shifting = (state == SHIFT) && cfg_enable;
  assign last_bit = (bit_cnt == BW'(CHAIN_BITS - 1));

  always_comb begin
    state_n    = state;
    mode_n     = mode_rb;
    bit_cnt_n  = bit_cnt;
    clr_cnt_n  = clr_cnt;
    rd_data_n  = rd_data;
    rd_valid_n = rd_valid;
    tx_clear   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    rx_clear   = 1'b0;
    rx_shift   = 1'b0;

    if (rd_valid && rd_ready) begin
      rd_valid_n = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          mode_n    = readback;
          bit_cnt_n = '0;
          clr_cnt_n = '0;
          tx_clear  = 1'b1;
          rx_clear  = 1'b1;
          state_n   = readback ? SHIFT : CLEAR;
        end
      end
      CLEAR: begin
        clr_cnt_n = clr_cnt + 1'b1;
        if (clr_cnt == CCW'(CLEAR_CYCLES - 1)) begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (wr_valid && wr_ready) begin
          tx_load = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (shifting) begin
          bit_cnt_n = bit_cnt + 1'b1;
          if (!mode_rb) begin
            tx_shift = 1'b1;
            if (last_bit) begin
              state_n = FINISH;
            end else if (tx_count == WCW'(WORD_WIDTH - 1)) begin
              state_n = FETCH;
            end
          end else begin
            rx_shift = 1'b1;
            // Stall logic guarantees the output slot is free on this edge.
            if (last_bit || (rx_count == WCW'(WORD_WIDTH - 1))) begin
              rd_data_n  = rx_assembled;
              rd_valid_n = 1'b1;
              rx_clear   = 1'b1;
            end
            if (last_bit) begin
              state_n = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (rd_valid && rd_ready) begin
          state_n = FINISH;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    wr_ready_n   = (state_n == FETCH);
    cfg_nreset_n = (state_n != CLEAR);
    busy_n       = (state_n != IDLE) && (state_n != FINISH);
    done_n       = (state_n == FINISH);
  end

  // Readback enable for the coming cycle: hold off the shift that would
  // complete a word while the previous word is still waiting in rd_data.
  assign rd_word_due_n = (bit_cnt_n == BW'(CHAIN_BITS - 1)) ||
                         (rx_count_next == WCW'(WORD_WIDTH - 1));
  assign cfg_enable_n  = (state_n == SHIFT) &&
                         (!mode_n || !(rd_word_due_n && rd_valid_n));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mode_rb    <= 1'b0;
      bit_cnt    <= '0;
      clr_cnt    <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_enable <= 1'b0;
      cfg_nreset <= 1'b1;
    end else begin
      state      <= state_n;
      mode_rb    <= mode_n;
      bit_cnt    <= bit_cnt_n;
      clr_cnt    <= clr_cnt_n;
      rd_data    <= rd_data_n;
      rd_valid   <= rd_valid_n;
      wr_ready   <= wr_ready_n;
      busy       <= busy_n;
      done       <= done_n;
      cfg_enable <= cfg_enable_n;
      cfg_nreset <= cfg_nreset_n;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader on a 70-flop chain with 32-bit words.
module tb_config_loader;
  import cfg_pkg::*;

  localparam int W  = 32;
  localparam int N  = 70;
  localparam int CC = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         start, readback, wr_valid, rd_ready;
  logic [W-1:0] wr_data, rd_data;
  logic         wr_ready, rd_valid, busy, done;
  logic         cfg_data_out, cfg_data_in, cfg_enable, cfg_nreset;
  logic [2:0]   state_dbg;

  config_loader #(.WORD_WIDTH(W), .CHAIN_BITS(N), .CLEAR_CYCLES(CC)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .readback     (readback),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .done         (done),
    .cfg_data_out (cfg_data_out),
    .cfg_data_in  (cfg_data_in),
    .cfg_enable   (cfg_enable),
    .cfg_nreset   (cfg_nreset),
    .state_dbg    (state_dbg)
  );

  // Behavioural fabric chain: synchronous clear, head is bit 0, tail bit N-1.
  logic [N-1:0] chain;
  always @(posedge clock) begin
    if (!cfg_nreset) chain <= '0;
    else if (cfg_enable) chain <= {chain[N-2:0], cfg_data_out};
  end
  assign cfg_data_in = chain[N-1];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int fails  = 0;
  logic [W-1:0] words[3];
  logic [W-1:0] exp_rd[3];
  logic [W-1:0] rd_got[3];
  logic [N-1:0] exp_chain;

  int m_nrst, m_en, m_done, m_hs, m_viol, m_clear_rdy, m_nrd, m_en_release;
  bit m_timeout;

  // Stream bit k (bit k%32 of word k/32) ends up k places from the tail.
  function automatic logic [N-1:0] build_chain(input logic [W-1:0] w0,
                                               input logic [W-1:0] w1,
                                               input logic [W-1:0] w2);
    logic [3*W-1:0] stream;
    logic [N-1:0]   c;
    stream = {w2, w1, w0};
    for (int k = 0; k < N; k++) c[N-1-k] = stream[k];
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_write(input bit rand_valid, input bit poke_start, input int reset_at);
    int idx, post;
    idx = 0; post = -1;
    m_nrst = 0; m_en = 0; m_done = 0; m_hs = 0; m_viol = 0; m_clear_rdy = 0;
    m_timeout = 1'b1;
    @(negedge clock);
    start = 1'b1; readback = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (!cfg_nreset) m_nrst++;
      if (cfg_enable) m_en++;
      if (done) m_done++;
      if (cfg_enable && wr_ready) m_viol++;
      if (wr_ready && !cfg_nreset) m_clear_rdy++;
      if (reset_at >= 0 && m_en == reset_at) begin
        m_timeout = 1'b0;
        break;
      end
      if (poke_start && m_en == 20) begin
        start = 1'b1; readback = 1'b1;
      end
      if (done && post < 0) post = 0;
      if (post >= 0) begin
        post++;
        if (post == 4) begin
          m_timeout = 1'b0;
          break;
        end
      end
      wr_valid = (idx < 3) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (idx < 3) wr_data = words[idx];
      else wr_data = '0;
      if (wr_valid && wr_ready) begin
        idx++;
        m_hs++;
      end
    end
    wr_valid = 1'b0;
    readback = 1'b0;
  endtask

  task automatic run_read(input int hold);
    int post, hold_left;
    post = -1; hold_left = -1;
    m_nrst = 0; m_en = 0; m_done = 0; m_nrd = 0; m_en_release = -1;
    m_timeout = 1'b1;
    for (int i = 0; i < 3; i++) rd_got[i] = '0;
    @(negedge clock);
    start = 1'b1; readback = 1'b1; rd_ready = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (!cfg_nreset) m_nrst++;
      if (cfg_enable) m_en++;
      if (done) m_done++;
      if (hold > 0 && hold_left < 0 && rd_valid) hold_left = hold;
      if (hold_left > 0) begin
        rd_ready = 1'b0;
        hold_left--;
        if (hold_left == 0) m_en_release = m_en;
      end else begin
        rd_ready = 1'b1;
      end
      if (rd_valid && rd_ready) begin
        if (m_nrd < 3) rd_got[m_nrd] = rd_data;
        m_nrd++;
      end
      if (done && post < 0) post = 0;
      if (post >= 0) begin
        post++;
        if (post == 4) begin
          m_timeout = 1'b0;
          break;
        end
      end
    end
    readback = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; readback = 1'b0; wr_valid = 1'b0;
    wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cfg_data_out !== 1'b0) begin fails++; $display("FAIL reset_cfg_data_out: got %b expected 0", cfg_data_out); end
    checks++; if (cfg_enable !== 1'b0) begin fails++; $display("FAIL reset_cfg_enable: got %b expected 0", cfg_enable); end
    checks++; if (cfg_nreset !== 1'b1) begin fails++; $display("FAIL reset_cfg_nreset: got %b expected 1", cfg_nreset); end
    checks++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_write(input string tag);
    checks++; if (m_timeout) begin fails++; $display("FAIL %s_timeout: no done within budget", tag); end
    checks++; if (m_nrst != CC) begin fails++; $display("FAIL %s_clear_cycles: got %0d expected %0d", tag, m_nrst, CC); end
    checks++; if (m_en != N) begin fails++; $display("FAIL %s_enable_cycles: got %0d expected %0d", tag, m_en, N); end
    checks++; if (m_done != 1) begin fails++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, m_done); end
    checks++; if (m_hs != 3) begin fails++; $display("FAIL %s_wr_handshakes: got %0d expected 3", tag, m_hs); end
    checks++; if (m_viol != 0) begin fails++; $display("FAIL %s_enable_in_fetch: got %0d expected 0", tag, m_viol); end
    checks++; if (m_clear_rdy != 0) begin fails++; $display("FAIL %s_ready_in_clear: got %0d expected 0", tag, m_clear_rdy); end
    checks++; if (chain !== exp_chain) begin fails++; $display("FAIL %s_chain: got %h expected %h", tag, chain, exp_chain); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_after: got %b expected 0", tag, busy); end
  endtask

  task automatic test_write_load();
    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'h0000003A;
    run_write(1'b0, 1'b0, -1);
    check_write("write");
  endtask

  // Random wr_valid gaps, junk in the discarded upper bits of word 2, and a
  // stray readback start while busy: the chain must come out the same.
  task automatic test_write_random();
    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'hABCDEF3A;
    run_write(1'b1, 1'b1, -1);
    check_write("write_rand");
  endtask

  task automatic check_read(input string tag);
    checks++; if (m_timeout) begin fails++; $display("FAIL %s_timeout: no done within budget", tag); end
    checks++; if (m_nrd != 3) begin fails++; $display("FAIL %s_word_count: got %0d expected 3", tag, m_nrd); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_got[i] !== exp_rd[i]) begin
        fails++; $display("FAIL %s_word%0d: got %h expected %h", tag, i, rd_got[i], exp_rd[i]);
      end
    end
    checks++; if (m_en != N) begin fails++; $display("FAIL %s_enable_cycles: got %0d expected %0d", tag, m_en, N); end
    checks++; if (m_nrst != 0) begin fails++; $display("FAIL %s_clear_cycles: got %0d expected 0", tag, m_nrst); end
    checks++; if (m_done != 1) begin fails++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, m_done); end
    checks++; if (chain !== exp_chain) begin fails++; $display("FAIL %s_chain_kept: got %h expected %h", tag, chain, exp_chain); end
  endtask

  task automatic test_readback();
    run_read(0);
    check_read("readback");
  endtask

  // Consumer stalls from the first word long enough that the second word
  // completes while the first is still pending.
  task automatic test_readback_stall();
    run_read(40);
    check_read("rb_stall");
    checks++;
    if (m_en_release != 63) begin
      fails++; $display("FAIL rb_stall_point: got %0d expected 63", m_en_release);
    end
  endtask

  task automatic test_reset_mid_load();
    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'h0000003A;
    run_write(1'b0, 1'b0, 40);
    checks++; if (m_timeout) begin fails++; $display("FAIL midrst_reach: bit 40 not reached"); end
    reset = 1'b1; wr_valid = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (cfg_enable !== 1'b0) begin fails++; $display("FAIL midrst_enable: got %b expected 0", cfg_enable); end
    checks++; if (cfg_nreset !== 1'b1) begin fails++; $display("FAIL midrst_nreset: got %b expected 1", cfg_nreset); end
    checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL midrst_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", done); end
    reset = 1'b0;
    @(negedge clock);
    run_write(1'b0, 1'b0, -1);
    check_write("reload");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    exp_chain = build_chain(32'hDEADBEEF, 32'h12345678, 32'h0000003A);
    exp_rd[0] = 32'hDEADBEEF;
    exp_rd[1] = 32'h12345678;
    exp_rd[2] = 32'h0000003A;
    test_reset();
    test_write_load();
    test_write_random();
    test_readback();
    test_readback_stall();
    test_reset_mid_load();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
